// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit:
// funct3 encodings, FSM states and access-size helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Bytes touched by an access; 0 marks an illegal funct3.
    function automatic logic [2:0] lsu_size(input logic [2:0] f3);
        logic [2:0] s;
        case (f3)
            3'b000, 3'b100: s = 3'd1;
            3'b001, 3'b101: s = 3'd2;
            3'b010:         s = 3'd4;
            default:        s = 3'd0;
        endcase
        return s;
    endfunction

    function automatic logic lsu_cross(input logic [1:0] off,
                                       input logic [2:0] size);
        return (({1'b0, off} + size) > 3'd4);
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane datapath: store merge across two words and
// load shift-and-extend from the captured word pair.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [31:0] wr_lo,
    output logic [31:0] wr_hi,
    output logic [31:0] rdata
);

    logic [2:0]  size;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [63:0] old;
    logic [63:0] merged;
    logic [63:0] raw;

    assign size = lsu_size(funct3);
    assign mask = ((8'd1 << size) - 8'd1) << off;
    assign data = {32'd0, wdata} << {off, 3'b000};
    assign old  = {hi, lo};
    assign raw  = old >> {off, 3'b000};

    always_comb begin
        merged = old;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) merged[8*i +: 8] = data[8*i +: 8];
        end
    end

    assign wr_lo = merged[31:0];
    assign wr_hi = merged[63:32];

    always_comb begin
        rdata = 32'd0;
        case (funct3)
            F3_LB:   rdata = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   rdata = {{16{raw[15]}}, raw[15:0]};
            F3_LW:   rdata = raw[31:0];
            F3_LBU:  rdata = {24'd0, raw[7:0]};
            F3_LHU:  rdata = {16'd0, raw[15:0]};
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment FSM between execute and a word-only
// data memory; sub-word stores use read-modify-write.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              access_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    state_t            nxt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_q;

    logic [2:0]        req_size;
    logic              req_cross;
    logic              bad_req;
    logic              req_full;
    logic              cross_q;
    logic [ADDR_W-1:0] word_lo;
    logic [ADDR_W-1:0] word_hi;
    logic [31:0]       wr_lo;
    logic [31:0]       wr_hi;
    logic [31:0]       ext;

    assign req_size  = lsu_size(req_funct3);
    assign req_cross = lsu_cross(req_addr[1:0], req_size);
    assign bad_req   = (req_size == 3'd0)
                     || (req_we && req_funct3[2])
                     || (req_cross && !ALLOW_MISALIGN);
    assign req_full  = req_we && (req_size == 3'd4)
                     && (req_addr[1:0] == 2'b00);

    assign cross_q = lsu_cross(addr_q[1:0], lsu_size(f3_q));
    assign word_lo = {addr_q[ADDR_W-1:2], 2'b00};
    // Wraps modulo the address space, so the last byte pairs with word 0.
    assign word_hi = word_lo + ADDR_W'(4);

    lsu_lane_merge u_merge (
        .funct3 (f3_q),
        .off    (addr_q[1:0]),
        .wdata  (wdata_q),
        .lo     (lo_q),
        .hi     (hi_q),
        .wr_lo  (wr_lo),
        .wr_hi  (wr_hi),
        .rdata  (ext)
    );

    always_comb begin
        nxt        = state;
        stall      = 1'b0;
        access_err = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        if (!rst) begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        stall = 1'b1;
                        if (bad_req) access_err = 1'b1;
                        else if (req_full) nxt = S_WR_LO;
                        else nxt = S_RD_LO;
                    end
                end
                S_RD_LO: begin
                    stall    = 1'b1;
                    mem_read = 1'b1;
                    mem_addr = word_lo;
                    if (cross_q) nxt = S_RD_HI;
                    else nxt = we_q ? S_WR_LO : S_DONE;
                end
                S_RD_HI: begin
                    stall    = 1'b1;
                    mem_read = 1'b1;
                    mem_addr = word_hi;
                    nxt      = we_q ? S_WR_LO : S_DONE;
                end
                S_WR_LO: begin
                    stall     = 1'b1;
                    mem_write = 1'b1;
                    mem_addr  = word_lo;
                    mem_wdata = wr_lo;
                    nxt       = cross_q ? S_WR_HI : S_DONE;
                end
                S_WR_HI: begin
                    stall     = 1'b1;
                    mem_write = 1'b1;
                    mem_addr  = word_hi;
                    mem_wdata = wr_hi;
                    nxt       = S_DONE;
                end
                S_DONE: begin
                    resp_valid = 1'b1;
                    resp_rdata = we_q ? 32'd0 : ext;
                    nxt        = S_IDLE;
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == S_RD_LO) lo_q <= mem_rdata;
            if (state == S_RD_HI) hi_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a behavioural word memory
// and a response scoreboard.
module tb_lsu_align;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid0 = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [8:0]  req_addr = 9'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        stall, resp_valid, access_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [8:0]  mem_addr;

    logic        stall0, resp_valid0, access_err0, mem_read0, mem_write0;
    logic [31:0] resp_rdata0, mem_wdata0;
    logic [31:0] mem_rdata0 = 32'd0;
    logic [8:0]  mem_addr0;

    logic [31:0] mem [128];
    logic        pl_en = 1'b0;
    logic [6:0]  pl_idx = 7'd0;
    logic [31:0] pl_data = 32'd0;

    int          pass_cnt = 0;
    int          total = 0;
    logic [31:0] exp_q[$];
    logic [8:0]  addr_log[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;
        else if (pl_en) mem[pl_idx] <= pl_data;
    end
    assign mem_rdata = mem[mem_addr[8:2]];

    lsu_align #(.ADDR_W(9), .ALLOW_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .access_err(access_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    lsu_align #(.ADDR_W(9), .ALLOW_MISALIGN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .stall(stall0), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .access_err(access_err0),
        .mem_read(mem_read0), .mem_write(mem_write0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pl_idx  = idx[6:0];
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we,
                          input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int lat);
        int n;
        bit got;
        logic [31:0] e;
        addr_log.delete();
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        exp_q.push_back(rd);
        n   = 1;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_addr  = 9'h155;
            req_wdata = 32'hDEADBEEF;
            @(negedge clk);
            n++;
            if (mem_read || mem_write) addr_log.push_back(mem_addr);
            if (resp_valid) begin
                got = 1'b1;
                e = exp_q.pop_front();
                chk({tag, "_rdata"}, resp_rdata, e);
                chk({tag, "_lat"}, 32'(n), 32'(lat));
                chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
            end
        end
        if (!got) begin
            total++;
            $error("FAIL %s_timeout: got no resp expected resp", tag);
        end
    endtask

    initial begin
        bit seen;
        req_valid  = 1'b1;
        req_funct3 = F3_LW;
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_err", {31'd0, access_err}, 32'd0);
        chk("rst_rd", {31'd0, mem_read}, 32'd0);
        chk("rst_resp", {31'd0, resp_valid}, 32'd0);
        req_valid = 1'b0;
        preload(0, 32'h8899AABB);
        preload(1, 32'h00000000);
        preload(2, 32'h44332211);
        preload(3, 32'h88776655);
        preload(127, 32'h11223344);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_stall", {31'd0, stall}, 32'd0);

        do_req("lb3", 1'b0, F3_LB, 9'h003, 0, 32'hFFFFFF88, 3);
        do_req("sb5", 1'b1, F3_SB, 9'h005, 32'h123456EF, 0, 4);
        chk("sb5_mem", mem[1], 32'h0000EF00);
        chk("sb5_n", 32'(addr_log.size()), 32'd2);
        do_req("lbu5", 1'b0, F3_LBU, 9'h005, 0, 32'h000000EF, 3);
        do_req("lwa", 1'b0, F3_LW, 9'h00A, 0, 32'h66554433, 4);
        do_req("swb", 1'b1, F3_SW, 9'h00B, 32'hDDCCBBAA, 0, 6);
        chk("swb_w2", mem[2], 32'hAA332211);
        chk("swb_w3", mem[3], 32'h88DDCCBB);
        chk("swb_n", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            chk("swb_a0", {23'd0, addr_log[0]}, 32'h008);
            chk("swb_a1", {23'd0, addr_log[1]}, 32'h00C);
            chk("swb_a2", {23'd0, addr_log[2]}, 32'h008);
            chk("swb_a3", {23'd0, addr_log[3]}, 32'h00C);
        end
        do_req("sw10", 1'b1, F3_SW, 9'h010, 32'hCAFEBABE, 0, 3);
        chk("sw10_mem", mem[4], 32'hCAFEBABE);
        chk("sw10_n", 32'(addr_log.size()), 32'd1);
        do_req("lhe", 1'b0, F3_LH, 9'h00E, 0, 32'hFFFF88DD, 3);
        do_req("lhu2", 1'b0, F3_LHU, 9'h002, 0, 32'h00008899, 3);
        do_req("lhwrap", 1'b0, F3_LH, 9'h1FF, 0, 32'hFFFFBB11, 4);
        chk("wrap_n", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() == 2) begin
            chk("wrap_lo", {23'd0, addr_log[0]}, 32'h1FC);
            chk("wrap_hi", {23'd0, addr_log[1]}, 32'h000);
        end

        @(negedge clk);
        req_valid0 = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_LH;
        req_addr   = 9'h1FF;
        #1;
        chk("nomis_err", {31'd0, access_err0}, 32'd1);
        chk("nomis_stall", {31'd0, stall0}, 32'd1);
        chk("nomis_rd", {31'd0, mem_read0}, 32'd0);
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        @(negedge clk);
        chk("nomis_err2", {31'd0, access_err0}, 32'd0);
        chk("nomis_rd2", {31'd0, mem_read0}, 32'd0);
        chk("nomis_idle", {31'd0, stall0}, 32'd0);

        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = 3'b011;
        req_addr   = 9'h000;
        #1;
        chk("f3_err", {31'd0, access_err}, 32'd1);
        @(posedge clk);
        #1;
        req_we     = 1'b1;
        req_funct3 = F3_LBU;
        @(negedge clk);
        chk("stlbu_err", {31'd0, access_err}, 32'd1);
        chk("err_rd", {31'd0, mem_read}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_we = 1'b0;
        @(negedge clk);
        chk("err_idle", {31'd0, stall | mem_read | mem_write}, 32'd0);

        req_valid  = 1'b1;
        req_funct3 = F3_LW;
        req_addr   = 9'h00A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rh_rd", {31'd0, mem_read}, 32'd1);
        chk("rh_addr", {23'd0, mem_addr}, 32'h00C);
        rst = 1'b1;
        #1;
        chk("rh_rst_rd", {31'd0, mem_read}, 32'd0);
        chk("rh_rst_addr", {23'd0, mem_addr}, 32'h000);
        chk("rh_rst_stall", {31'd0, stall}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | resp_valid | mem_read;
        end
        chk("rh_noresp", {31'd0, seen}, 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
